// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and lane helpers for the data-memory controller
// Contents: size codes, FSM state type, byte-enable mask, store lane steering,
// alignment check and load extraction (offset, size, unsigned, word -> 32-bit).
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef logic [3:0] be_t;

  typedef enum logic {CLEAR, RUN} state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = off[0];
      SZ_WORD: r = (off != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic be_t be_mask(input logic [1:0] size, input logic [1:0] off);
    be_t r;
    case (size)
      SZ_BYTE: r = be_t'(4'b0001 << off);
      SZ_HALF: r = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: r = 4'b1111;
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

  // Replicate right-aligned store data so every candidate lane carries it;
  // the byte enables then pick the lane(s) actually written.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {4{wdata[7:0]}};
      SZ_HALF: r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] off, input logic [1:0] size,
                                               input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// rtl/dmem_bram.sv - single-port DEPTHx32 RAM with per-byte write enables
// Ports: clk; en (access this cycle); we[3:0] byte enables; addr word index;
// wdata write data; rdata registered read data (old contents on a write cycle).
module dmem_bram #(
  parameter int DEPTH = 32768,
  parameter int AW    = 15
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (we[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: sub-word store/load formatting over a byte-enabled RAM
// Ports: clk, rst (sync, active-high); request side req_valid/req_ready/req_we/
// req_addr/req_size/req_unsigned/req_wdata; response side resp_valid/resp_rdata/
// resp_misalign, one response per accepted request after READ_LATENCY cycles.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 17,
  parameter int DEPTH          = 32768,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state, state_next;
  logic [AW-1:0] clr_idx;
  logic          clr_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    clr_write  = 1'b0;
    case (state)
      CLEAR: begin
        clr_write = 1'b1;
        if (clr_idx == AW'(DEPTH - 1)) state_next = RUN;
      end
      RUN: req_ready = 1'b1;
      default: state_next = RUN;
    endcase
    // Nothing is accepted or cleared on the reset cycle itself.
    if (rst) begin
      req_ready = 1'b0;
      clr_write = 1'b0;
    end
  end

  logic          accept, mis;
  logic [1:0]    off;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          addr_unused;

  assign accept = req_valid && req_ready;
  assign off    = req_addr[1:0];
  assign mis    = is_misaligned(req_size, off);

  // Index bits above log2(DEPTH) are dropped so the address wraps.
  assign addr_unused = ^(req_addr >> (AW + 2));

  assign ram_en    = accept || clr_write;
  assign ram_we    = clr_write ? 4'hF
                   : (accept && req_we && !mis) ? be_mask(req_size, off) : 4'h0;
  assign ram_addr  = clr_write ? clr_idx : req_addr[AW+1:2];
  assign ram_wdata = clr_write ? 32'b0 : store_lanes(req_size, req_wdata);

  dmem_bram #(.DEPTH(DEPTH), .AW(AW)) u_bram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Request attributes travel alongside the RAM read so the lane can be picked.
  logic        s1_valid, s1_load, s1_mis, s1_uns;
  logic [1:0]  s1_off, s1_size;
  logic [31:0] s1_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_load  <= 1'b0;
      s1_mis   <= 1'b0;
      s1_uns   <= 1'b0;
      s1_off   <= 2'b00;
      s1_size  <= 2'b00;
    end else begin
      s1_valid <= accept;
      s1_load  <= accept && !req_we && !mis;
      s1_mis   <= accept && mis;
      s1_uns   <= req_unsigned;
      s1_off   <= off;
      s1_size  <= req_size;
    end
  end

  assign s1_data = s1_load ? load_extract(s1_off, s1_size, s1_uns, ram_rdata) : 32'b0;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic        s2_valid, s2_mis;
      logic [31:0] s2_data;
      always_ff @(posedge clk) begin
        if (rst) begin
          s2_valid <= 1'b0;
          s2_mis   <= 1'b0;
          s2_data  <= 32'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_mis   <= s1_mis;
          s2_data  <= s1_data;
        end
      end
      assign resp_valid    = s2_valid;
      assign resp_misalign = s2_mis;
      assign resp_rdata    = s2_data;
    end else begin : g_lat1
      assign resp_valid    = s1_valid;
      assign resp_misalign = s1_mis;
      assign resp_rdata    = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl (latency-1 instance and latency-2 clearing instance)
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst2, valid1, valid2, we, uns;
  logic [16:0] addr;
  logic [1:0]  size;
  logic [31:0] wdata;
  logic        ready1, rvalid1, mis1, ready2, rvalid2, mis2;
  logic [31:0] rdata1, rdata2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          due;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(.ADDR_W(17), .DEPTH(32768), .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut1 (
    .clk(clk), .rst(rst1), .req_valid(valid1), .req_ready(ready1), .req_we(we),
    .req_addr(addr), .req_size(size), .req_unsigned(uns), .req_wdata(wdata),
    .resp_valid(rvalid1), .resp_rdata(rdata1), .resp_misalign(mis1));

  dmem_ctrl #(.ADDR_W(10), .DEPTH(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(valid2), .req_ready(ready2), .req_we(we),
    .req_addr(addr[9:0]), .req_size(size), .req_unsigned(uns), .req_wdata(wdata),
    .resp_valid(rvalid2), .resp_rdata(rdata2), .resp_misalign(mis2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive one request for one cycle and record its expected response.
  task automatic op(input int sel, input logic w, input logic [16:0] a, input logic [1:0] sz,
                    input logic u, input logic [31:0] wd, input logic [31:0] er, input logic em);
    exp_t e;
    we = w; addr = a; size = sz; uns = u; wdata = wd;
    valid1 = (sel == 1); valid2 = (sel == 2);
    e.rdata = er; e.mis = em;
    if (sel == 1) begin
      chk("d1 req_ready", {31'b0, ready1}, 32'd1);
      e.due = cyc + 1; q1.push_back(e);
    end else begin
      chk("d2 req_ready", {31'b0, ready2}, 32'd1);
      e.due = cyc + 2; q2.push_back(e);
    end
    @(negedge clk);
    valid1 = 1'b0; valid2 = 1'b0;
  endtask

  task automatic ld(input int sel, input logic [16:0] a, input logic [1:0] sz, input logic u,
                    input logic [31:0] er, input logic em);
    op(sel, 1'b0, a, sz, u, 32'h0, er, em);
  endtask

  task automatic st(input int sel, input logic [16:0] a, input logic [1:0] sz,
                    input logic [31:0] wd, input logic em);
    op(sel, 1'b1, a, sz, 1'b0, wd, 32'h0, em);
  endtask

  // dut2 must hold req_ready low for exactly 16 cycles after reset release and
  // ignore stores offered meanwhile.
  task automatic clear_check();
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("d2 ready during clear", {31'b0, ready2}, 32'd0);
      chk("d2 resp_valid during clear", {31'b0, rvalid2}, 32'd0);
      we = 1'b1; addr = 17'h10; size = SZ_WORD; wdata = 32'hFFFF_FFFF; valid2 = 1'b1;
      @(negedge clk);
    end
    valid2 = 1'b0;
    #1;
    chk("d2 ready after clear", {31'b0, ready2}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (rvalid1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL d1 unexpected response: rdata %h mis %b (cycle %0d)", rdata1, mis1, cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("d1 rdata", rdata1, e.rdata);
        chk("d1 misalign", {31'b0, mis1}, {31'b0, e.mis});
        chk("d1 latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  always @(negedge clk) begin
    if (rvalid2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL d2 unexpected response: rdata %h mis %b (cycle %0d)", rdata2, mis2, cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("d2 rdata", rdata2, e.rdata);
        chk("d2 misalign", {31'b0, mis2}, {31'b0, e.mis});
        chk("d2 latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; valid1 = 1'b0; valid2 = 1'b0;
    we = 1'b0; uns = 1'b0; addr = '0; size = SZ_WORD; wdata = '0;
    @(negedge clk);
    chk("d1 reset resp_valid", {31'b0, rvalid1}, 32'd0);
    chk("d1 reset rdata", rdata1, 32'd0);
    chk("d1 reset misalign", {31'b0, mis1}, 32'd0);
    chk("d1 reset req_ready", {31'b0, ready1}, 32'd0);
    chk("d2 reset resp_valid", {31'b0, rvalid2}, 32'd0);
    chk("d2 reset rdata", rdata2, 32'd0);
    chk("d2 reset misalign", {31'b0, mis2}, 32'd0);
    chk("d2 reset req_ready", {31'b0, ready2}, 32'd0);
    @(negedge clk);
    rst1 = 1'b0; rst2 = 1'b0;
    clear_check();

    // Latency-1 instance: sub-word formatting and alignment faults.
    st(1, 17'h10, SZ_WORD, 32'h1234_5678, 1'b0);
    ld(1, 17'h10, SZ_WORD, 1'b0, 32'h1234_5678, 1'b0);
    ld(1, 17'h13, SZ_BYTE, 1'b0, 32'h0000_0012, 1'b0);
    ld(1, 17'h12, SZ_HALF, 1'b0, 32'h0000_1234, 1'b0);
    st(1, 17'h11, SZ_BYTE, 32'h0000_0080, 1'b0);
    ld(1, 17'h11, SZ_BYTE, 1'b0, 32'hFFFF_FF80, 1'b0);
    ld(1, 17'h11, SZ_BYTE, 1'b1, 32'h0000_0080, 1'b0);
    st(1, 17'h11, SZ_HALF, 32'h0000_BEEF, 1'b1);
    ld(1, 17'h10, SZ_WORD, 1'b0, 32'h1234_8078, 1'b0);
    ld(1, 17'h12, SZ_WORD, 1'b0, 32'h0, 1'b1);
    ld(1, 17'h10, 2'b11, 1'b0, 32'h0, 1'b1);
    st(1, 17'h12, SZ_HALF, 32'h0000_BEEF, 1'b0);
    ld(1, 17'h12, SZ_HALF, 1'b0, 32'hFFFF_BEEF, 1'b0);
    ld(1, 17'h12, SZ_HALF, 1'b1, 32'h0000_BEEF, 1'b0);
    ld(1, 17'h10, SZ_BYTE, 1'b1, 32'h0000_0078, 1'b0);
    ld(1, 17'h10, SZ_HALF, 1'b0, 32'hFFFF_8078, 1'b0);
    st(1, 17'h14, SZ_WORD, 32'hCAFE_F00D, 1'b0);
    ld(1, 17'h14, SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b0);
    st(1, 17'h14, 2'b11, 32'h0, 1'b1);
    ld(1, 17'h14, SZ_WORD, 1'b0, 32'hCAFE_F00D, 1'b0);
    ld(1, 17'h10, SZ_WORD, 1'b0, 32'hBEEF_8078, 1'b0);

    // Latency-2 clearing instance: back-to-back, read-after-write, wrap.
    st(2, 17'h20, SZ_WORD, 32'hA5A5_1234, 1'b0);
    ld(2, 17'h20, SZ_WORD, 1'b0, 32'hA5A5_1234, 1'b0);
    ld(2, 17'h24, SZ_WORD, 1'b0, 32'h0, 1'b0);
    st(2, 17'h25, SZ_BYTE, 32'h0000_007F, 1'b0);
    ld(2, 17'h24, SZ_HALF, 1'b0, 32'h0000_7F00, 1'b0);
    st(2, 17'h10, SZ_WORD, 32'h1122_3344, 1'b0);
    ld(2, 17'h50, SZ_WORD, 1'b0, 32'h1122_3344, 1'b0);
    ld(2, 17'h60, SZ_WORD, 1'b0, 32'hA5A5_1234, 1'b0);
    repeat (3) @(negedge clk);

    // A load in flight when reset hits must never be presented.
    we = 1'b0; addr = 17'h10; size = SZ_WORD; uns = 1'b0; valid2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b1; addr = 17'h20;
    @(negedge clk);
    valid2 = 1'b0;
    chk("d2 dropped response", {31'b0, rvalid2}, 32'd0);
    rst2 = 1'b0;
    clear_check();
    for (int i = 0; i < 16; i++) ld(2, 17'(i * 4), SZ_WORD, 1'b0, 32'h0, 1'b0);

    repeat (4) @(negedge clk);
    if (q1.size() != 0) begin
      checks++; errors++;
      $display("FAIL d1 missing responses: got %0d pending expected 0", q1.size());
    end
    if (q2.size() != 0) begin
      checks++; errors++;
      $display("FAIL d2 missing responses: got %0d pending expected 0", q2.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
